// File: rtl/tb_run_controller.sv
// -----------------------------------------------------------------------------
// tb_run_controller
//
// Synthesisable run controller for multi-hart core benches. It holds the core
// wrappers in reset for a fixed number of cycles after the bench reset is
// released. It then counts run cycles against a programmable watchdog and
// gathers per-hart pass/fail/exit reports into a single sticky verdict.
//
// Ports
//   clk_i          clock
//   rst_i          synchronous, active-high reset
//   max_cycles_i   watchdog limit in RUN cycles (0 disables the watchdog)
//   wait_all_i     1: finish once every hart has reported, 0: on first report
//   passed_i       per-hart "tests passed" indication
//   failed_i       per-hart "tests failed" indication
//   exit_valid_i   per-hart exit report valid
//   exit_value_i   per-hart exit value, hart h at [h*EXIT_WIDTH +: EXIT_WIDTH]
//   core_rst_no    active-low reset to the core wrappers
//   cycle_cnt_o    RUN cycles elapsed (saturating)
//   hart_done_o    sticky per-hart "has reported" flags
//   done_o         sticky run-finished flag
//   result_o       0 none, 1 pass, 2 fail, 3 timeout
//   exit_value_o   exit value of the first failing hart, else 0
//   fail_hart_o    index of the first failing hart, else 0
// -----------------------------------------------------------------------------
module tb_run_controller #(
  parameter int NUM_HARTS         = 1,
  parameter int CNT_WIDTH         = 32,
  parameter int EXIT_WIDTH        = 32,
  parameter int RESET_WAIT_CYCLES = 4,
  parameter int IDX_W             = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [CNT_WIDTH-1:0]            max_cycles_i,
  input  logic                            wait_all_i,
  input  logic [NUM_HARTS-1:0]            passed_i,
  input  logic [NUM_HARTS-1:0]            failed_i,
  input  logic [NUM_HARTS-1:0]            exit_valid_i,
  input  logic [NUM_HARTS*EXIT_WIDTH-1:0] exit_value_i,
  output logic                            core_rst_no,
  output logic [CNT_WIDTH-1:0]            cycle_cnt_o,
  output logic [NUM_HARTS-1:0]            hart_done_o,
  output logic                            done_o,
  output logic [1:0]                      result_o,
  output logic [EXIT_WIDTH-1:0]           exit_value_o,
  output logic [IDX_W-1:0]                fail_hart_o
);

  localparam int                   HOLD_W    = $clog2(RESET_WAIT_CYCLES + 1);
  localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(RESET_WAIT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};

  localparam logic [1:0] RES_NONE    = 2'd0;
  localparam logic [1:0] RES_PASS    = 2'd1;
  localparam logic [1:0] RES_FAIL    = 2'd2;
  localparam logic [1:0] RES_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [HOLD_W-1:0]       hold_cnt_q, hold_cnt_d;
  logic                    core_rst_n_q, core_rst_n_d;
  logic [CNT_WIDTH-1:0]    cycle_cnt_q, cycle_cnt_d;
  logic [NUM_HARTS-1:0]    hart_done_q, hart_done_d;
  logic                    done_q, done_d;
  logic [1:0]              result_q, result_d;
  logic [EXIT_WIDTH-1:0]   exit_value_q, exit_value_d;
  logic [IDX_W-1:0]        fail_hart_q, fail_hart_d;

  logic [NUM_HARTS-1:0]    exit_nz_s;
  logic [NUM_HARTS-1:0]    new_report_s;
  logic [NUM_HARTS-1:0]    new_fail_s;
  logic [NUM_HARTS-1:0]    captured_s;
  logic                    pass_complete_s;
  logic                    timeout_s;
  logic [IDX_W-1:0]        first_idx_s;
  logic [EXIT_WIDTH-1:0]   first_exit_s;
  logic [CNT_WIDTH-1:0]    cnt_inc_s;

  // Lowest set index of a hart vector; descending scan so the lowest hit wins.
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_HARTS-1:0] vec);
    logic [IDX_W-1:0] r;
    r = {IDX_W{1'b0}};
    for (int h = NUM_HARTS - 1; h >= 0; h--) begin
      if (vec[h]) r = IDX_W'(h);
    end
    return r;
  endfunction

  // Exit value reported by the lowest set hart of vec, or 0 if it gave none.
  function automatic logic [EXIT_WIDTH-1:0] lowest_exit(
    input logic [NUM_HARTS-1:0]            vec,
    input logic [NUM_HARTS-1:0]            valid,
    input logic [NUM_HARTS*EXIT_WIDTH-1:0] values
  );
    logic [EXIT_WIDTH-1:0] r;
    r = {EXIT_WIDTH{1'b0}};
    for (int h = NUM_HARTS - 1; h >= 0; h--) begin
      if (vec[h]) r = valid[h] ? values[h*EXIT_WIDTH +: EXIT_WIDTH] : {EXIT_WIDTH{1'b0}};
    end
    return r;
  endfunction

  // Per-hart flag: the presented exit value is non-zero.
  always_comb begin
    exit_nz_s = {NUM_HARTS{1'b0}};
    for (int h = 0; h < NUM_HARTS; h++) begin
      exit_nz_s[h] = |exit_value_i[h*EXIT_WIDTH +: EXIT_WIDTH];
    end
  end

  // Only harts that have not yet reported contribute this cycle.
  assign new_report_s = ~hart_done_q & (passed_i | failed_i | exit_valid_i);
  assign new_fail_s   = ~hart_done_q & (failed_i | (exit_valid_i & exit_nz_s));
  assign captured_s   = hart_done_q | new_report_s;

  // Completion is judged on the post-capture hart set of this cycle.
  assign pass_complete_s = wait_all_i ? (&captured_s) : (|captured_s);
  assign timeout_s       = (max_cycles_i != {CNT_WIDTH{1'b0}}) &&
                           (cycle_cnt_q == (max_cycles_i - CNT_WIDTH'(1'b1)));

  assign first_idx_s  = lowest_idx(new_fail_s);
  assign first_exit_s = lowest_exit(new_fail_s, exit_valid_i, exit_value_i);
  assign cnt_inc_s    = (cycle_cnt_q == CNT_MAX) ? cycle_cnt_q
                                                 : cycle_cnt_q + CNT_WIDTH'(1'b1);

  // Next-state and next-output logic for the HOLD -> RUN -> DONE sequence.
  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    core_rst_n_d = core_rst_n_q;
    cycle_cnt_d  = cycle_cnt_q;
    hart_done_d  = hart_done_q;
    done_d       = done_q;
    result_d     = result_q;
    exit_value_d = exit_value_q;
    fail_hart_d  = fail_hart_q;
    case (state_q)
      ST_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d      = ST_RUN;
          hold_cnt_d   = {HOLD_W{1'b0}};
          core_rst_n_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1'b1);
        end
      end
      ST_RUN: begin
        // The count advances even on the edge that ends the run, so a
        // timeout leaves cycle_cnt_o equal to the limit.
        cycle_cnt_d = cnt_inc_s;
        hart_done_d = captured_s;
        if (|new_fail_s) begin
          state_d      = ST_DONE;
          done_d       = 1'b1;
          result_d     = RES_FAIL;
          fail_hart_d  = first_idx_s;
          exit_value_d = first_exit_s;
        end else if (pass_complete_s) begin
          state_d  = ST_DONE;
          done_d   = 1'b1;
          result_d = RES_PASS;
        end else if (timeout_s) begin
          state_d  = ST_DONE;
          done_d   = 1'b1;
          result_d = RES_TIMEOUT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d      = ST_HOLD;
        hold_cnt_d   = {HOLD_W{1'b0}};
        core_rst_n_d = 1'b0;
        cycle_cnt_d  = {CNT_WIDTH{1'b0}};
        hart_done_d  = {NUM_HARTS{1'b0}};
        done_d       = 1'b0;
        result_d     = RES_NONE;
        exit_value_d = {EXIT_WIDTH{1'b0}};
        fail_hart_d  = {IDX_W{1'b0}};
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_HOLD;
      hold_cnt_q   <= {HOLD_W{1'b0}};
      core_rst_n_q <= 1'b0;
      cycle_cnt_q  <= {CNT_WIDTH{1'b0}};
      hart_done_q  <= {NUM_HARTS{1'b0}};
      done_q       <= 1'b0;
      result_q     <= RES_NONE;
      exit_value_q <= {EXIT_WIDTH{1'b0}};
      fail_hart_q  <= {IDX_W{1'b0}};
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      core_rst_n_q <= core_rst_n_d;
      cycle_cnt_q  <= cycle_cnt_d;
      hart_done_q  <= hart_done_d;
      done_q       <= done_d;
      result_q     <= result_d;
      exit_value_q <= exit_value_d;
      fail_hart_q  <= fail_hart_d;
    end
  end

  assign core_rst_no  = core_rst_n_q;
  assign cycle_cnt_o  = cycle_cnt_q;
  assign hart_done_o  = hart_done_q;
  assign done_o       = done_q;
  assign result_o     = result_q;
  assign exit_value_o = exit_value_q;
  assign fail_hart_o  = fail_hart_q;

endmodule

// File: tb/tb_tb_run_controller.sv
// -----------------------------------------------------------------------------
// Self-checking bench for tb_run_controller (4 harts, 4-cycle reset hold).
// A directed vector table, hand-written multi-cycle sequences and a random
// phase all run against a behavioural reference model that is compared with
// the DUT after every clock edge.
// -----------------------------------------------------------------------------
module tb_tb_run_controller;

  localparam int NH  = 4;
  localparam int CW  = 32;
  localparam int EW  = 32;
  localparam int RWC = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [CW-1:0]     maxc;
  logic              wa;
  logic [NH-1:0]     p, f, ev;
  logic [NH*EW-1:0]  xv;
  logic              crn;
  logic [CW-1:0]     cnt;
  logic [NH-1:0]     hd;
  logic              done;
  logic [1:0]        res;
  logic [EW-1:0]     exv;
  logic [1:0]        fh;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tb_run_controller #(
    .NUM_HARTS(NH), .CNT_WIDTH(CW), .EXIT_WIDTH(EW), .RESET_WAIT_CYCLES(RWC)
  ) dut (
    .clk_i(clk), .rst_i(rst), .max_cycles_i(maxc), .wait_all_i(wa),
    .passed_i(p), .failed_i(f), .exit_valid_i(ev), .exit_value_i(xv),
    .core_rst_no(crn), .cycle_cnt_o(cnt), .hart_done_o(hd), .done_o(done),
    .result_o(res), .exit_value_o(exv), .fail_hart_o(fh)
  );

  // ---------------- reference model ----------------
  int          m_hold;
  bit          m_run, m_done, m_crn;
  longint      m_cnt;
  logic [3:0]  m_hd;
  int          m_res;
  logic [31:0] m_exv;
  int          m_fh;

  task automatic model_update();
    if (rst) begin
      m_hold = RWC; m_run = 0; m_done = 0; m_crn = 0; m_cnt = 0;
      m_hd = '0; m_res = 0; m_exv = '0; m_fh = 0;
    end else if (m_done) begin
      // frozen until reset
    end else if (!m_run) begin
      m_hold--;
      if (m_hold == 0) begin
        m_run = 1; m_crn = 1;
      end
    end else begin
      int     first_fail;
      int     reported;
      longint old;
      bit     finish;
      first_fail = -1; reported = 0; old = m_cnt; finish = 0;
      for (int h = 0; h < NH; h++) begin
        if (!m_hd[h] && (p[h] || f[h] || ev[h])) begin
          m_hd[h] = 1'b1;
          if ((f[h] || (ev[h] && xv[h*EW +: EW] != 0)) && first_fail < 0) first_fail = h;
        end
      end
      for (int h = 0; h < NH; h++) reported += int'(m_hd[h]);
      if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
      if (first_fail >= 0) begin
        m_res = 2; m_fh = first_fail;
        m_exv = ev[first_fail] ? xv[first_fail*EW +: EW] : 32'h0;
        finish = 1;
      end else if ((!wa && reported > 0) || (wa && reported == NH)) begin
        m_res = 1; finish = 1;
      end else if (maxc != 0 && old == longint'(maxc) - 1) begin
        m_res = 3; finish = 1;
      end
      if (finish) begin
        m_run = 0; m_done = 1;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("mdl_core_rst_n", 32'(crn), 32'(m_crn));
    chk("mdl_cycle_cnt", cnt, m_cnt[31:0]);
    chk("mdl_hart_done", 32'(hd), 32'(m_hd));
    chk("mdl_done", 32'(done), 32'(m_done));
    chk("mdl_result", 32'(res), 32'(m_res));
    chk("mdl_exit_value", exv, m_exv);
    chk("mdl_fail_hart", 32'(fh), 32'(m_fh));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare_model();
  endtask

  task automatic clear_in();
    p = '0; f = '0; ev = '0; xv = '0;
  endtask

  task automatic idle(input int n);
    clear_in();
    repeat (n) step();
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    repeat (RWC) step();
    chk("reset_release_crn", 32'(crn), 32'd1);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          rst;
    logic [3:0]  p, f, ev;
    logic [31:0] xv;
    bit          crn;
    int          cnt;
    logic [3:0]  hd;
    bit          done;
    int          res;
    logic [31:0] exv;
    int          fh;
  } vec_t;

  vec_t tbl[20];

  initial begin
    int n;
    int dwell;

    tbl[0]  = '{1'b1, 4'h0, 4'h0, 4'h0, 32'h0, 1'b0, 0, 4'h0, 1'b0, 0, 32'h0, 0};
    tbl[1]  = '{1'b1, 4'h0, 4'h0, 4'h0, 32'h0, 1'b0, 0, 4'h0, 1'b0, 0, 32'h0, 0};
    tbl[2]  = '{1'b0, 4'h0, 4'h0, 4'h0, 32'h0, 1'b0, 0, 4'h0, 1'b0, 0, 32'h0, 0};
    tbl[3]  = '{1'b0, 4'hF, 4'h0, 4'h0, 32'h0, 1'b0, 0, 4'h0, 1'b0, 0, 32'h0, 0};
    tbl[4]  = '{1'b0, 4'h0, 4'hF, 4'hF, 32'h9, 1'b0, 0, 4'h0, 1'b0, 0, 32'h0, 0};
    tbl[5]  = '{1'b0, 4'h0, 4'h0, 4'h0, 32'h0, 1'b1, 0, 4'h0, 1'b0, 0, 32'h0, 0};
    tbl[6]  = '{1'b0, 4'h0, 4'h0, 4'h0, 32'h0, 1'b1, 1, 4'h0, 1'b0, 0, 32'h0, 0};
    tbl[7]  = '{1'b0, 4'h0, 4'h0, 4'h0, 32'h0, 1'b1, 2, 4'h0, 1'b0, 0, 32'h0, 0};
    tbl[8]  = '{1'b0, 4'h0, 4'h0, 4'h0, 32'h0, 1'b1, 3, 4'h0, 1'b0, 0, 32'h0, 0};
    tbl[9]  = '{1'b0, 4'h0, 4'h0, 4'h1, 32'h7, 1'b1, 4, 4'h1, 1'b1, 2, 32'h7, 0};
    tbl[10] = '{1'b0, 4'h0, 4'h0, 4'h1, 32'h7, 1'b1, 4, 4'h1, 1'b1, 2, 32'h7, 0};
    tbl[11] = '{1'b0, 4'hF, 4'hF, 4'h0, 32'h0, 1'b1, 4, 4'h1, 1'b1, 2, 32'h7, 0};
    tbl[12] = '{1'b1, 4'h0, 4'h0, 4'h0, 32'h0, 1'b0, 0, 4'h0, 1'b0, 0, 32'h0, 0};
    tbl[13] = '{1'b0, 4'h0, 4'h0, 4'h0, 32'h0, 1'b0, 0, 4'h0, 1'b0, 0, 32'h0, 0};
    tbl[14] = '{1'b0, 4'h0, 4'h0, 4'h0, 32'h0, 1'b0, 0, 4'h0, 1'b0, 0, 32'h0, 0};
    tbl[15] = '{1'b0, 4'h0, 4'h0, 4'h0, 32'h0, 1'b0, 0, 4'h0, 1'b0, 0, 32'h0, 0};
    tbl[16] = '{1'b0, 4'h0, 4'h0, 4'h0, 32'h0, 1'b1, 0, 4'h0, 1'b0, 0, 32'h0, 0};
    tbl[17] = '{1'b0, 4'h0, 4'h0, 4'h1, 32'h0, 1'b1, 1, 4'h1, 1'b1, 1, 32'h0, 0};
    tbl[18] = '{1'b0, 4'h0, 4'h1, 4'h0, 32'h0, 1'b1, 1, 4'h1, 1'b1, 1, 32'h0, 0};
    tbl[19] = '{1'b1, 4'h0, 4'h0, 4'h0, 32'h0, 1'b0, 0, 4'h0, 1'b0, 0, 32'h0, 0};

    rst = 1'b1; wa = 1'b0; maxc = '0;
    clear_in();

    for (int i = 0; i < 20; i++) begin
      rst = tbl[i].rst; p = tbl[i].p; f = tbl[i].f; ev = tbl[i].ev;
      xv = {NH{tbl[i].xv}};
      step();
      chk($sformatf("vec%0d_crn", i), 32'(crn), 32'(tbl[i].crn));
      chk($sformatf("vec%0d_cnt", i), cnt, 32'(tbl[i].cnt));
      chk($sformatf("vec%0d_hd", i), 32'(hd), 32'(tbl[i].hd));
      chk($sformatf("vec%0d_done", i), 32'(done), 32'(tbl[i].done));
      chk($sformatf("vec%0d_res", i), 32'(res), 32'(tbl[i].res));
      chk($sformatf("vec%0d_exv", i), exv, tbl[i].exv);
      chk($sformatf("vec%0d_fh", i), 32'(fh), 32'(tbl[i].fh));
    end

    // Single pass at cnt=10, then frozen through later reports and idle time.
    wa = 1'b0; maxc = '0;
    do_reset();
    idle(10);
    chk("pass_pre_cnt", cnt, 32'd10);
    p = 4'h1;
    step();
    chk("pass_done", 32'(done), 32'd1);
    chk("pass_res", 32'(res), 32'd1);
    chk("pass_hd", 32'(hd), 32'h1);
    chk("pass_cnt", cnt, 32'd11);
    p = 4'h0; f = 4'hF; ev = 4'hF; xv = {NH{32'h3}};
    step();
    idle(50);
    chk("frozen_cnt", cnt, 32'd11);
    chk("frozen_res", 32'(res), 32'd1);
    chk("frozen_hd", 32'(hd), 32'h1);
    chk("frozen_exv", exv, 32'h0);

    // wait_all: harts 2,0,3 then 1.
    wa = 1'b1;
    do_reset();
    p = 4'b0100; step();
    p = 4'b0000; step();
    p = 4'b0001; step();
    p = 4'b1000; step();
    chk("wall_partial_done", 32'(done), 32'd0);
    chk("wall_partial_hd", 32'(hd), 32'hD);
    p = 4'b0010; step();
    chk("wall_done", 32'(done), 32'd1);
    chk("wall_res", 32'(res), 32'd1);
    chk("wall_hd", 32'(hd), 32'hF);

    // Harts 1 and 3 fail together; hart 3 reports exit 0x55.
    do_reset();
    f = 4'b0010; ev = 4'b1000; xv = {32'h55, 32'h0, 32'h0, 32'h0};
    step();
    chk("mfail_res", 32'(res), 32'd2);
    chk("mfail_fh", 32'(fh), 32'd1);
    chk("mfail_exv", exv, 32'h0);
    chk("mfail_hd", 32'(hd), 32'hA);

    // Watchdog timeout at 100 run cycles.
    wa = 1'b0; maxc = 32'd100;
    do_reset();
    clear_in();
    n = 0;
    while (!done && n < 200) begin
      step();
      n++;
    end
    chk("wdog_cycles", 32'(n), 32'd100);
    chk("wdog_done", 32'(done), 32'd1);
    chk("wdog_res", 32'(res), 32'd3);
    chk("wdog_cnt", cnt, 32'd100);

    // Completion in the same cycle as the timeout wins.
    do_reset();
    idle(99);
    chk("wdog_race_pre", cnt, 32'd99);
    p = 4'h1;
    step();
    chk("wdog_race_res", 32'(res), 32'd1);
    chk("wdog_race_cnt", cnt, 32'd100);

    // Watchdog disabled.
    maxc = '0;
    do_reset();
    idle(5000);
    chk("nowdog_done", 32'(done), 32'd0);
    chk("nowdog_cnt", cnt, 32'd5000);

    // Reset mid-run at cycle 37, then the hold sequence restarts.
    do_reset();
    idle(37);
    chk("midrst_pre_cnt", cnt, 32'd37);
    rst = 1'b1;
    step();
    chk("midrst_crn", 32'(crn), 32'd0);
    chk("midrst_cnt", cnt, 32'd0);
    rst = 1'b0;
    for (int k = 0; k < RWC - 1; k++) begin
      step();
      chk("midrst_hold_crn", 32'(crn), 32'd0);
    end
    step();
    chk("midrst_run_crn", 32'(crn), 32'd1);

    // Random phase against the model.
    dwell = 0;
    for (int c = 0; c < 3000; c++) begin
      rst = 1'b0;
      if (m_done) dwell++;
      else dwell = 0;
      if (dwell > 3 || $urandom_range(0, 399) == 0) begin
        rst = 1'b1; dwell = 0;
        wa = 1'($urandom_range(0, 1));
        maxc = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(1, 80));
      end
      if ($urandom_range(0, 99) == 0) maxc = 32'($urandom_range(0, 80));
      if ($urandom_range(0, 99) == 0) wa = ~wa;
      for (int h = 0; h < NH; h++) begin
        p[h]  = ($urandom_range(0, 29) == 0);
        f[h]  = ($urandom_range(0, 199) == 0);
        ev[h] = ($urandom_range(0, 49) == 0);
        xv[h*EW +: EW] = ($urandom_range(0, 1) == 0) ? 32'h0 : 32'($urandom);
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
